// File: rtl/instr_byte_loader_pkg.sv
// rtl/instr_byte_loader_pkg.sv - shared types and constants for the instruction byte loader
package instr_byte_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/instr_byte_loader_sync_rise.sv
// rtl/instr_byte_loader_sync_rise.sv - 2-FF synchronizer with registered rising-edge pulse
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise   <= sync_q & ~prev_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/instr_byte_loader.sv
// rtl/instr_byte_loader.sv - assembles pin bytes into LE words and writes instruction memory
module instr_byte_loader
    import instr_byte_loader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              byte_stb,
    input  logic [7:0]        byte_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              load_busy,
    output logic              mem_full,
    output logic              ovf
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic load_sync;
    logic load_rise_unused;
    logic stb_rise;

    sync_rise u_sync_load (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (load_en),
        .sync_out (load_sync),
        .rise     (load_rise_unused)
    );

    sync_rise u_sync_stb (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (byte_stb),
        .sync_out (),
        .rise     (stb_rise)
    );

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  byte_idx;
    logic [IDX_W-1:0]  idx_after;
    logic [WORD_W-1:0] word_buf;
    logic [WORD_W-1:0] word_nxt;
    logic              accept;
    logic              full_now;
    logic              take_byte;
    logic              enter_load;

    // A write still in flight at the last address already counts as full.
    assign full_now  = mem_full | (mem_we & (mem_addr == LAST_ADDR));
    assign accept    = stb_rise & (state == ST_LOAD);
    assign take_byte = accept & ~full_now;
    assign idx_after = take_byte ? byte_idx + 1'b1 : byte_idx;
    // Unfilled lanes of word_buf are always zero, so OR-ing the new lane in is enough.
    assign word_nxt  = word_buf | (WORD_W'(byte_data) << {byte_idx, 3'b000});

    always_comb begin
        state_nxt  = state;
        cpu_run    = 1'b0;
        load_busy  = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = load_sync ? ST_LOAD : ST_RUN;
            end
            ST_LOAD: begin
                load_busy = 1'b1;
                if (!load_sync) begin
                    state_nxt = (idx_after != '0) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                load_busy = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                cpu_run = 1'b1;
                if (load_sync) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        enter_load = (state_nxt == ST_LOAD) && (state != ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            byte_idx  <= '0;
            word_buf  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_full  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state  <= state_nxt;
            mem_we <= 1'b0;
            if (enter_load) begin
                byte_idx <= '0;
                word_buf <= '0;
                mem_addr <= '0;
                mem_full <= 1'b0;
                ovf      <= 1'b0;
            end else begin
                if (mem_we) begin
                    if (mem_addr == LAST_ADDR) begin
                        mem_full <= 1'b1;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                if (accept && full_now) begin
                    ovf <= 1'b1;
                end
                if (take_byte) begin
                    if (idx_after == '0) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= word_nxt;
                        word_buf  <= '0;
                    end else begin
                        word_buf  <= word_nxt;
                    end
                    byte_idx <= idx_after;
                end
                // Partial word goes out in the FLUSH cycle itself.
                if (state == ST_LOAD && state_nxt == ST_FLUSH) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= take_byte ? word_nxt : word_buf;
                end
                if (state == ST_FLUSH) begin
                    byte_idx <= '0;
                    word_buf <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_byte_loader.sv
// tb/tb_instr_byte_loader.sv - scoreboard bench for instr_byte_loader
module tb_instr_byte_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic        byte_stb;
    logic [7:0]  byte_data;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        load_busy;
    logic        mem_full;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    instr_byte_loader #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .byte_stb  (byte_stb),
        .byte_data (byte_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_run   (cpu_run),
        .load_busy (load_busy),
        .mem_full  (mem_full),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                             mem_addr, mem_wdata, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_data = b;
        cyc(2);
        byte_stb = 1'b1;
        cyc(5);
        byte_stb = 1'b0;
        cyc(5);
    endtask

    task automatic wait_busy(input logic val, input string name);
        int n;
        n = 0;
        while (load_busy !== val && n < 20) begin
            cyc(1);
            n++;
        end
        chk(name, {31'd0, load_busy}, {31'd0, val});
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        rst_n = 1'b0; load_en = 1'b0; byte_stb = 1'b0; byte_data = 8'h00;
        cyc(3);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_flags", {28'd0, cpu_run, load_busy, mem_full, ovf}, 32'd0);
        rst_n = 1'b1;

        // Single word, then release CPU three edges after load_en drops.
        load_en = 1'b1;
        wait_busy(1'b1, "enter_load1");
        chk("halt_in_load1", {31'd0, cpu_run}, 32'd0);
        push(5'd0, 32'h0000_0013);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        load_en = 1'b0;
        cyc(2);
        chk("still_halted", {31'd0, cpu_run}, 32'd0);
        cyc(1);
        chk("run_after_load1", {31'd0, cpu_run}, 32'd1);
        chk("addr_after_load1", {27'd0, mem_addr}, 32'd1);

        // Two words back to back; busy stays high.
        load_en = 1'b1;
        wait_busy(1'b1, "enter_load2");
        chk("addr_cleared2", {27'd0, mem_addr}, 32'd0);
        push(5'd0, 32'h0403_0201);
        push(5'd1, 32'h0807_0605);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i));
            chk($sformatf("busy_byte%0d", i), {31'd0, load_busy}, 32'd1);
        end
        load_en = 1'b0;
        wait_busy(1'b0, "exit_load2");

        // Five bytes then flush of the partial word.
        load_en = 1'b1;
        wait_busy(1'b1, "enter_load3");
        push(5'd0, 32'h0403_0201);
        push(5'd1, 32'h0000_0005);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        load_en = 1'b0;
        cyc(3);
        chk("flush_state", {30'd0, load_busy, cpu_run}, 32'd2);
        chk("flush_we", {31'd0, mem_we}, 32'd1);
        cyc(1);
        chk("run_after_flush", {30'd0, load_busy, cpu_run}, 32'd1);
        chk("addr_after_flush", {27'd0, mem_addr}, 32'd2);

        // Fill all 32 words, then overflow with a 33rd word.
        load_en = 1'b1;
        wait_busy(1'b1, "enter_load4");
        for (int w = 0; w < 32; w++) begin
            push(5'(w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        end
        for (int k = 0; k < 128; k++) send_byte(8'(k));
        chk("full_after_128", {30'd0, mem_full, ovf}, 32'd2);
        chk("addr_sat_128", {27'd0, mem_addr}, 32'd31);
        send_byte(8'hEE);
        chk("ovf_after_129", {30'd0, mem_full, ovf}, 32'd3);
        send_byte(8'hEE); send_byte(8'hEE); send_byte(8'hEE);
        chk("addr_sat_132", {27'd0, mem_addr}, 32'd31);
        load_en = 1'b0;
        cyc(4);
        chk("run_after_full", {31'd0, cpu_run}, 32'd1);
        chk("flags_sticky_run", {30'd0, mem_full, ovf}, 32'd3);

        // Re-enter LOAD from RUN: flags and address clear.
        load_en = 1'b1;
        wait_busy(1'b1, "enter_load5");
        chk("reload_cleared", {25'd0, cpu_run, mem_full, ovf, mem_addr}, 32'd0);
        push(5'd0, 32'h1122_3344);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        chk("addr_after_reload", {27'd0, mem_addr}, 32'd1);

        // Reset mid-word drops the partial word.
        send_byte(8'h55); send_byte(8'h66);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("midrst_outputs", {21'd0, cpu_run, load_busy, mem_full, ovf, 2'd0, mem_addr}, 32'd0);
        chk("midrst_wdata", mem_wdata, 32'd0);
        cyc(1);
        rst_n = 1'b1;
        wait_busy(1'b1, "enter_load6");
        push(5'd0, 32'hDDCC_BBAA);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        load_en = 1'b0;
        cyc(4);
        chk("final_run", {31'd0, cpu_run}, 32'd1);
        chk("pending_writes", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
